// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC owner: redirect, squash, fetch bubbles, misalign trap, redirect counter
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BUBBLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        misalign_err,
    output logic        halted,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Bubble count loaded on every accepted redirect; covers the IMEM read latency.
    localparam logic [2:0] BUB_INIT = 3'(BUBBLES);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  bub_cnt;
    logic [2:0]  bub_cnt_nxt;
    logic [31:0] pc_nxt;
    logic [15:0] count_nxt;

    logic        target_aligned;
    logic        redirect_live;
    logic        accept;
    logic        trap;

    // Redirect decode: a halted core ignores EX entirely, so neither accept nor trap can fire there.
    assign target_aligned = (redirect_target[1:0] == 2'b00);
    assign redirect_live  = redirect_valid && (state != ST_HALT);
    assign accept         = redirect_live && target_aligned;
    assign trap           = redirect_live && !target_aligned;

    assign pc_plus4 = pc + 32'd4;

    // Squash both front-end registers on any redirect event; suppressed while in reset.
    assign flush_ifid = !rst && (accept || trap);
    assign flush_idex = !rst && (accept || trap);

    assign fetch_valid = (state == ST_RUN);
    assign halted      = (state == ST_HALT);

    // Next-state, next-PC and bubble counter; redirect wins over stall.
    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        pc_nxt      = pc;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    pc_nxt      = redirect_target;
                    bub_cnt_nxt = BUB_INIT;
                    state_nxt   = ST_FLUSH;
                end else if (trap) begin
                    state_nxt = ST_HALT;
                end else if (!stall) begin
                    pc_nxt = pc_plus4;
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    pc_nxt      = redirect_target;
                    bub_cnt_nxt = BUB_INIT;
                end else if (trap) begin
                    state_nxt = ST_HALT;
                end else if (!stall) begin
                    pc_nxt      = pc_plus4;
                    bub_cnt_nxt = bub_cnt - 3'd1;
                    if (bub_cnt == 3'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Saturating count of accepted redirects; traps are not counted.
    always_comb begin
        count_nxt = redirect_count;
        if (accept && (redirect_count != 16'hFFFF)) begin
            count_nxt = redirect_count + 16'd1;
        end
    end

    // State register; misalign_err is a one-cycle echo of the trap decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            bub_cnt        <= 3'd0;
            pc             <= RESET_PC;
            redirect_count <= 16'd0;
            misalign_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            bub_cnt        <= bub_cnt_nxt;
            pc             <= pc_nxt;
            redirect_count <= count_nxt;
            misalign_err   <= trap;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic [31:0] pc0, pp40, pc1, pp41;
    logic        fv0, fi0, fd0, err0, hlt0;
    logic        fv1, fi1, fd1, err1, hlt1;
    logic [15:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    localparam int          MB  [2] = '{1, 3};
    localparam logic [31:0] RPC [2] = '{32'h0000_0100, 32'h0000_2000};

    // Reference model: PC, remaining bubbles, halted flag, trap pulse, redirect count
    logic [31:0] m_pc   [2];
    int          m_left [2];
    bit          m_halt [2];
    bit          m_err  [2];
    int          m_cnt  [2];

    pc_redirect_ctrl #(.RESET_PC(32'h0000_0100), .BUBBLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc(pc0), .pc_plus4(pp40), .fetch_valid(fv0),
        .flush_ifid(fi0), .flush_idex(fd0), .misalign_err(err0),
        .halted(hlt0), .redirect_count(cnt0)
    );

    pc_redirect_ctrl #(.RESET_PC(32'h0000_2000), .BUBBLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc(pc1), .pc_plus4(pp41), .fetch_valid(fv1),
        .flush_ifid(fi1), .flush_idex(fd1), .misalign_err(err1),
        .halted(hlt1), .redirect_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pc[i]   = RPC[i];
                m_left[i] = 0;
                m_halt[i] = 1'b0;
                m_err[i]  = 1'b0;
                m_cnt[i]  = 0;
            end else begin
                m_err[i] = 1'b0;
                if (!m_halt[i]) begin
                    if (redirect_valid && redirect_target[1:0] != 2'b00) begin
                        m_halt[i] = 1'b1;
                        m_err[i]  = 1'b1;
                    end else if (redirect_valid) begin
                        m_pc[i]   = redirect_target;
                        m_left[i] = MB[i];
                        if (m_cnt[i] < 65535) m_cnt[i]++;
                    end else if (!stall) begin
                        m_pc[i] = m_pc[i] + 32'd4;
                        if (m_left[i] > 0) m_left[i]--;
                    end
                end
            end
        end
    endtask

    task automatic check_regs(input int i, input logic [31:0] p, input logic [31:0] p4,
                              input logic fv, input logic er, input logic hl, input logic [15:0] c);
        chk($sformatf("i%0d_pc", i), p, m_pc[i]);
        chk($sformatf("i%0d_pc_plus4", i), p4, m_pc[i] + 32'd4);
        chk($sformatf("i%0d_fetch_valid", i), 32'(fv), 32'(!m_halt[i] && m_left[i] == 0));
        chk($sformatf("i%0d_misalign_err", i), 32'(er), 32'(m_err[i]));
        chk($sformatf("i%0d_halted", i), 32'(hl), 32'(m_halt[i]));
        chk($sformatf("i%0d_count", i), 32'(c), 32'(m_cnt[i]));
    endtask

    // One clock: check combinational flush before the edge, then registered outputs after it.
    task automatic cycle();
        logic ef0, ef1;
        #1;
        ef0 = !rst && !m_halt[0] && redirect_valid;
        ef1 = !rst && !m_halt[1] && redirect_valid;
        chk("i0_flush_ifid", 32'(fi0), 32'(ef0));
        chk("i0_flush_idex", 32'(fd0), 32'(ef0));
        chk("i1_flush_ifid", 32'(fi1), 32'(ef1));
        chk("i1_flush_idex", 32'(fd1), 32'(ef1));
        @(posedge clk);
        model_step();
        #1;
        check_regs(0, pc0, pp40, fv0, err0, hlt0, cnt0);
        check_regs(1, pc1, pp41, fv1, err1, hlt1, cnt1);
    endtask

    initial begin
        int guard;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h42;
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = '0; m_left[i] = 0; m_halt[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
        end

        // Reset held two cycles with a misaligned redirect present: flushes must stay low
        cycle();
        cycle();
        rst = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        chk("reset_pc", pc0, 32'h100);
        chk("reset_fv", 32'(fv0), 32'd1);
        chk("reset_count", 32'(cnt0), 32'd0);
        chk("reset_halted", 32'(hlt0), 32'd0);
        cycle(); chk("run_pc_104", pc0, 32'h104);
        cycle(); chk("run_pc_108", pc0, 32'h108);
        cycle(); chk("run_pc_10c", pc0, 32'h10C);

        // Free-run to 0x200, then redirect to 0x80
        for (int k = 0; k < 61; k++) cycle();
        chk("pc_at_200", pc0, 32'h200);
        redirect_valid = 1'b1; redirect_target = 32'h80;
        #1;
        chk("redir_flush_same_cycle", 32'(fi0), 32'd1);
        cycle();
        redirect_valid = 1'b0;
        chk("redir_pc_80", pc0, 32'h80);
        chk("redir_fv_low", 32'(fv0), 32'd0);
        cycle();
        chk("redir_pc_84", pc0, 32'h84);
        chk("redir_fv_high", 32'(fv0), 32'd1);
        chk("redir_count_1", 32'(cnt0), 32'd1);

        // Redirect beats stall; stall then holds PC and bubble count
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        chk("stall_redir_pc_40", pc0, 32'h40);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_hold_pc", pc0, 32'h40);
            chk("stall_hold_fv", 32'(fv0), 32'd0);
        end
        stall = 1'b0;
        cycle();
        chk("stall_release_pc", pc0, 32'h44);
        chk("stall_release_fv", 32'(fv0), 32'd1);

        // Misaligned target traps and halts
        redirect_valid = 1'b1; redirect_target = 32'h42;
        #1;
        chk("trap_flush", 32'(fd0), 32'd1);
        cycle();
        redirect_target = 32'h300;
        chk("trap_halted", 32'(hlt0), 32'd1);
        chk("trap_err_pulse", 32'(err0), 32'd1);
        chk("trap_pc_hold", pc0, 32'h44);
        chk("trap_count_hold", 32'(cnt0), 32'd2);
        cycle();
        chk("trap_err_cleared", 32'(err0), 32'd0);
        chk("halt_ignores_redir", pc0, 32'h44);
        cycle();
        redirect_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("halt_reset_pc", pc0, 32'h100);
        chk("halt_reset_halted", 32'(hlt0), 32'd0);

        // Back-to-back redirects
        redirect_valid = 1'b1; redirect_target = 32'h10;
        cycle();
        redirect_target = 32'h20;
        chk("b2b_pc_10", pc0, 32'h10);
        cycle();
        redirect_valid = 1'b0;
        chk("b2b_pc_20", pc0, 32'h20);
        chk("b2b_fv_low", 32'(fv0), 32'd0);
        cycle();
        chk("b2b_fv_high", 32'(fv0), 32'd1);
        chk("b2b_count_2", 32'(cnt0), 32'd2);

        // Drive the counter up to saturation with consecutive aligned redirects
        redirect_valid = 1'b1;
        guard = 0;
        while (m_cnt[0] < 32'hFFFE && guard < 70000) begin
            redirect_target = $urandom & 32'hFFFF_FFFC;
            cycle();
            guard++;
        end
        chk("sat_count_fffe", 32'(cnt0), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            redirect_target = $urandom & 32'hFFFF_FFFC;
            cycle();
            chk("sat_count_ffff", 32'(cnt0), 32'hFFFF);
        end

        // PC wrap at the top of the address space
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        chk("wrap_pc_top", pc0, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pp40, 32'h0);
        cycle();
        chk("wrap_pc_zero", pc0, 32'h0);

        // Randomized traffic against the model
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            rst             = ($urandom_range(0, 99) < 2);
            redirect_valid  = ($urandom_range(0, 3) == 0);
            stall           = ($urandom_range(0, 9) < 3);
            redirect_target = $urandom;
            if ($urandom_range(0, 7) != 0) redirect_target[1:0] = 2'b00;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
